// File: rtl/parity_scheduler.sv
// ---------------------------------------------------------------------------
// parity_scheduler
//
// Lets NUM_REQ byte sources share one bit-serial parity engine. In IDLE a
// round-robin arbiter grants one valid requester and captures its byte. The
// engine then folds one bit per cycle into a parity accumulator for 8 cycles.
// After that it presents {byte, parity} plus the owner's index on a
// valid/ready output, and holds it until the downstream side accepts it.
//
// Optional build macro:
//   PARITY_SCHED_ODD_PARITY_EN - when defined, the accumulator starts at 1,
//                                so the result bit is odd parity. When it is
//                                undefined, the result bit is even parity.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]    per-requester byte valid
//   req_data   in   [8*NUM_REQ]  byte of requester i on [8*i+7:8*i]
//   req_ready  out  [NUM_REQ]    one-hot grant in IDLE, otherwise zero
//   out_valid  out               result available (DONE state)
//   out_ready  in                downstream accepts the result
//   out_data   out  [9]          {captured byte, parity}, parity in bit 0
//   out_id     out  [ID_W]       index of the requester owning out_data
//   busy       out               FSM is not in IDLE
// ---------------------------------------------------------------------------
module parity_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8:0]             out_data,
    output logic [ID_W-1:0]        out_id,
    output logic                   busy
);

`ifdef PARITY_SCHED_ODD_PARITY_EN
    localparam logic ACC_INIT = 1'b1;
`else
    localparam logic ACC_INIT = 1'b0;
`endif

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q,  state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [2:0]      cnt_q,    cnt_d;
    logic [7:0]      sh_q,     sh_d;
    logic            acc_q,    acc_d;
    logic [ID_W-1:0] id_q,     id_d;

    logic            found;
    logic [ID_W-1:0] grant_idx;

    // Round-robin search: scan from rr_ptr upward, wrapping modulo NUM_REQ,
    // and take the first requester that is valid.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    // The grant is also gated by rst_n, so nothing looks accepted while the
    // block is being held in reset.
    assign req_ready = (state_q == IDLE && found && rst_n)
                     ? (NUM_REQ'(1) << grant_idx) : '0;

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = (state_q == DONE) ? {sh_q, acc_q} : 9'd0;
    assign out_id    = (state_q == DONE) ? id_q : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        acc_d    = acc_q;
        id_d     = id_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sh_d     = req_data[8*int'(grant_idx) +: 8];
                    id_d     = grant_idx;
                    acc_d    = ACC_INIT;
                    cnt_d    = 3'd0;
                    rr_ptr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // Rotate right, not shift. After 8 rotations the captured
                // byte is back in its original position, ready for out_data.
                acc_d = acc_q ^ sh_q[0];
                sh_d  = {sh_q[0], sh_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= 3'd0;
            sh_q     <= 8'd0;
            acc_q    <= ACC_INIT;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            acc_q    <= acc_d;
            id_q     <= id_d;
        end
    end

endmodule
